dp_sig_mul_pipe: RTL and testbench
==================================

// Module: dp_sig_mul_pipe
// PURPOSE
//  Pipelined multi-precision product stage for the 4D dot-product unit: LANES independent a*b lanes.
//  Per lane: sign XOR, biased exponent sum with range flags, and a split hi/lo significand multiply.
//  Mode 1 (FP32) forms the full SIG_W x SIG_W product from four partials; mode 0 (FP16) uses hi*hi only.
//  Valid/ready handshake on both sides, full stall support; feeds the alignment/adder-tree stage.
// PARAMETERS
//  LANES     4    number of parallel product lanes
//  EXP_W     8    exponent width; PRD_EXP_W = EXP_W+2 signed internal exponent
//  HI_W      12   upper significand slice width (only slice used in mode 0)
//  LO_W      13   lower significand slice width; SIG_W = HI_W+LO_W, PROD_W = 2*SIG_W
//  BIAS_F32  127  exponent bias, mode 1
//  BIAS_F16  15   exponent bias, mode 0
//  EMAX_F16  30   largest legal biased exponent, mode 0 (mode 1 limit = 2**EXP_W-2)
// PORTS
//  gclk       in   1              clock
//  rst        in   1              asynchronous reset, active-high
//  in_valid   in   1              input beat valid
//  in_ready   out  1              input beat accepted when in_valid & in_ready
//  mode       in   1              1 = FP32 full product, 0 = FP16 hi-slice product; sampled with beat
//  sign_a/b   in   LANES          operand signs, lane i at bit i
//  exp_a/b    in   LANES*EXP_W    biased exponents, lane i at [i*EXP_W +: EXP_W]
//  sig_a/b    in   LANES*SIG_W    significands; per lane hi slice = top HI_W bits, lo = bottom LO_W
//  out_valid  out  1              result beat valid
//  out_ready  in   1              downstream accepts when out_valid & out_ready
//  out_mode   out  1              mode of the beat on the output
//  sign_p     out  LANES          product signs
//  exp_p      out  LANES*EXP_W    product exponents (clamped)
//  sig_p      out  LANES*PROD_W   product significands
//  zero_p     out  LANES          lane product is zero
//  ovf_p      out  LANES          exponent overflow (exp_p saturated)
//  unf_p      out  LANES          exponent underflow (exp_p = 0, sig_p = 0)
// BEHAVIOUR
//  - Two register stages S1, S2, each with valid bit v1/v2. Latency 2 cycles accept -> out_valid.
//  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational, no in_valid dependence).
//  - S1 loads on in_valid & in_ready: four partials per lane hh=ahi*bhi, hl=ahi*blo, lh=alo*bhi,
//    ll=alo*blo; e = exp_a+exp_b-bias(mode) in PRD_EXP_W signed; sign XOR; zero = (exp_a==0)|(exp_b==0);
//    mode. In mode 0 hl/lh/ll registered as 0 regardless of lo slices.
//  - S2 loads from S1 when v1 & adv2: sig = (hh<<2*LO_W)+((hl+lh)<<LO_W)+ll, PROD_W bits, no truncation.
//  - Exponent range: emax = mode ? 2**EXP_W-2 : EMAX_F16. zero lane: exp_p=0, sig_p=0, ovf=unf=0.
//    else e>emax: exp_p=emax+1 (all-ones exp for the mode), ovf=1, sig_p unchanged.
//    else e<1: exp_p=0, sig_p=0, unf=1. else exp_p=e[EXP_W-1:0].
//  - sign_p always XOR of inputs, including zero/underflow lanes.
//  - Stall: while out_valid & !out_ready, S2 and all outputs hold stable; S1 holds if also valid;
//    in_ready drops only when both stages full. Back-to-back beats sustain 1 beat/cycle.
//  - Simultaneous drain and fill: out_ready=1 with v1=v2=1 -> S2<=S1 and S1<=new beat same edge.
//  - Valid bits clear when a stage empties with nothing arriving; data regs need not clear.
//  - Reset (any time, incl. mid-stall): v1=v2=0; out_valid=0, out_mode=0, sign_p/exp_p/sig_p/zero_p/
//    ovf_p/unf_p=0; in-flight beats discarded; in_ready=1 in first cycle after reset release.
//  - Lanes fully independent; mixed flags across lanes in one beat are legal.
// TESTING
//  - FP32, all lanes exp 127/127, sig 25'h0800000 each -> after 2 cycles exp_p=127, sig_p=2**46, flags 0.
//  - FP16, exp 15/15, hi slice 12'h400, lo slices 13'h1FFF -> exp_p=15, sig_p=2**46 (lo ignored).
//  - Lane0 exp_a=0, lane1 exp 200/200 FP32, lane2 exp 1/1 FP32 -> zero_p[0]=1, ovf_p[1]=1 exp 8'hFF,
//    unf_p[2]=1 exp/sig 0; lane3 normal, unaffected.
//  - 8 back-to-back beats, out_ready held 0 cycles 3-6 -> in_ready low once S1+S2 full, no beat lost/
//    duplicated, outputs stable during stall, order preserved, mode tag follows each beat.
//  - Alternating mode 1/0 beats with identical operands -> out_mode/bias/product switch per beat.
//  - rst asserted with v1=v2=1 during stall -> out_valid=0 immediately, all outputs 0, restart clean.

Source files
------------

// File: rtl/dp_sig_mul_pipe_if.sv
// Handshake bundle for the dot-product product stage: operand beat in, product beat out.
interface dp_sig_mul_pipe_if #(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int SIG_W = 25
);
  localparam int PROD_W = 2 * SIG_W;

  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [LANES-1:0]          sign_a;
  logic [LANES-1:0]          sign_b;
  logic [LANES*EXP_W-1:0]    exp_a;
  logic [LANES*EXP_W-1:0]    exp_b;
  logic [LANES*SIG_W-1:0]    sig_a;
  logic [LANES*SIG_W-1:0]    sig_b;

  logic                      out_valid;
  logic                      out_ready;
  logic                      out_mode;
  logic [LANES-1:0]          sign_p;
  logic [LANES*EXP_W-1:0]    exp_p;
  logic [LANES*PROD_W-1:0]   sig_p;
  logic [LANES-1:0]          zero_p;
  logic [LANES-1:0]          ovf_p;
  logic [LANES-1:0]          unf_p;

  modport slave (
    input  in_valid, mode, sign_a, sign_b, exp_a, exp_b, sig_a, sig_b, out_ready,
    output in_ready, out_valid, out_mode, sign_p, exp_p, sig_p, zero_p, ovf_p, unf_p
  );

  modport master (
    output in_valid, mode, sign_a, sign_b, exp_a, exp_b, sig_a, sig_b, out_ready,
    input  in_ready, out_valid, out_mode, sign_p, exp_p, sig_p, zero_p, ovf_p, unf_p
  );
endinterface

// File: rtl/dp_sig_mul_pipe.sv
// Two-stage per-lane product: S1 forms partial products and the raw exponent,
// S2 sums the partials and clamps the exponent range. Full valid/ready stall support.
module dp_sig_mul_pipe #(
  parameter int LANES    = 4,
  parameter int EXP_W    = 8,
  parameter int HI_W     = 12,
  parameter int LO_W     = 13,
  parameter int BIAS_F32 = 127,
  parameter int BIAS_F16 = 15,
  parameter int EMAX_F16 = 30
) (
  input  logic gclk,
  input  logic rst,
  dp_sig_mul_pipe_if.slave io_bus
);
  localparam int SIG_W     = HI_W + LO_W;
  localparam int PROD_W    = 2 * SIG_W;
  localparam int PRD_EXP_W = EXP_W + 2;
  localparam int HH_W      = 2 * HI_W;
  localparam int HL_W      = HI_W + LO_W;
  localparam int LL_W      = 2 * LO_W;

  localparam logic [PRD_EXP_W-1:0]        BIAS32 = PRD_EXP_W'(BIAS_F32);
  localparam logic [PRD_EXP_W-1:0]        BIAS16 = PRD_EXP_W'(BIAS_F16);
  localparam logic [PRD_EXP_W-1:0]        EMAX32 = PRD_EXP_W'((1 << EXP_W) - 2);
  localparam logic [PRD_EXP_W-1:0]        EMAX16 = PRD_EXP_W'(EMAX_F16);
  localparam logic signed [PRD_EXP_W-1:0] E_ONE  = PRD_EXP_W'(1);

  logic w_adv1, w_adv2, w_load1, w_load2;
  logic r_v1, r_v2;

  logic [LANES-1:0][HH_W-1:0]      w_hh, r_hh;
  logic [LANES-1:0][HL_W-1:0]      w_hl, w_lh, r_hl, r_lh;
  logic [LANES-1:0][LL_W-1:0]      w_ll, r_ll;
  logic [LANES-1:0][PRD_EXP_W-1:0] w_e, r_e;
  logic [LANES-1:0]                w_zero, r_zero1, r_sign1;
  logic                            r_mode1;

  logic [PRD_EXP_W-1:0]            w_emax, w_emax_p1;
  logic [LANES-1:0][PROD_W-1:0]    w_sum, w_sig2, r_sig2;
  logic [LANES-1:0][EXP_W-1:0]     w_exp2, r_exp2;
  logic [LANES-1:0]                w_ovf_c, w_unf_c, w_ovf2, w_unf2;
  logic [LANES-1:0]                r_sign2, r_zero2, r_ovf2, r_unf2;
  logic                            r_mode2;

  assign w_adv2  = !r_v2 || io_bus.out_ready;
  assign w_adv1  = !r_v1 || w_adv2;
  assign w_load1 = io_bus.in_valid && w_adv1;
  assign w_load2 = r_v1 && w_adv2;

  // FP16 beats only use the hi slices; the cross/low partials are forced to zero.
  always_comb begin
    w_hh   = '0;
    w_hl   = '0;
    w_lh   = '0;
    w_ll   = '0;
    w_e    = '0;
    w_zero = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hh[i] = HH_W'(io_bus.sig_a[i*SIG_W+LO_W +: HI_W]) * HH_W'(io_bus.sig_b[i*SIG_W+LO_W +: HI_W]);
      if (io_bus.mode) begin
        w_hl[i] = HL_W'(io_bus.sig_a[i*SIG_W+LO_W +: HI_W]) * HL_W'(io_bus.sig_b[i*SIG_W +: LO_W]);
        w_lh[i] = HL_W'(io_bus.sig_a[i*SIG_W +: LO_W]) * HL_W'(io_bus.sig_b[i*SIG_W+LO_W +: HI_W]);
        w_ll[i] = LL_W'(io_bus.sig_a[i*SIG_W +: LO_W]) * LL_W'(io_bus.sig_b[i*SIG_W +: LO_W]);
      end
      w_e[i] = PRD_EXP_W'(io_bus.exp_a[i*EXP_W +: EXP_W]) + PRD_EXP_W'(io_bus.exp_b[i*EXP_W +: EXP_W])
               - (io_bus.mode ? BIAS32 : BIAS16);
      w_zero[i] = (io_bus.exp_a[i*EXP_W +: EXP_W] == '0) || (io_bus.exp_b[i*EXP_W +: EXP_W] == '0);
    end
  end

  assign w_emax    = r_mode1 ? EMAX32 : EMAX16;
  assign w_emax_p1 = w_emax + PRD_EXP_W'(1);

  // Priority: zero lane, then overflow (significand kept), then underflow.
  always_comb begin
    w_sum   = '0;
    w_sig2  = '0;
    w_exp2  = '0;
    w_ovf_c = '0;
    w_unf_c = '0;
    w_ovf2  = '0;
    w_unf2  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i] = (PROD_W'(r_hh[i]) << (2 * LO_W))
               + ((PROD_W'(r_hl[i]) + PROD_W'(r_lh[i])) << LO_W)
               + PROD_W'(r_ll[i]);
      w_ovf_c[i] = $signed(r_e[i]) > $signed(w_emax);
      w_unf_c[i] = $signed(r_e[i]) < E_ONE;
      if (r_zero1[i]) begin
        w_exp2[i] = '0;
        w_sig2[i] = '0;
      end else if (w_ovf_c[i]) begin
        w_exp2[i] = w_emax_p1[EXP_W-1:0];
        w_sig2[i] = w_sum[i];
        w_ovf2[i] = 1'b1;
      end else if (w_unf_c[i]) begin
        w_exp2[i] = '0;
        w_sig2[i] = '0;
        w_unf2[i] = 1'b1;
      end else begin
        w_exp2[i] = r_e[i][EXP_W-1:0];
        w_sig2[i] = w_sum[i];
      end
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_hh    <= '0;
      r_hl    <= '0;
      r_lh    <= '0;
      r_ll    <= '0;
      r_e     <= '0;
      r_zero1 <= '0;
      r_sign1 <= '0;
      r_mode1 <= 1'b0;
      r_sig2  <= '0;
      r_exp2  <= '0;
      r_sign2 <= '0;
      r_zero2 <= '0;
      r_ovf2  <= '0;
      r_unf2  <= '0;
      r_mode2 <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= io_bus.in_valid;
      if (w_load1) begin
        r_hh    <= w_hh;
        r_hl    <= w_hl;
        r_lh    <= w_lh;
        r_ll    <= w_ll;
        r_e     <= w_e;
        r_zero1 <= w_zero;
        r_sign1 <= io_bus.sign_a ^ io_bus.sign_b;
        r_mode1 <= io_bus.mode;
      end
      if (w_adv2) r_v2 <= r_v1;
      if (w_load2) begin
        r_sig2  <= w_sig2;
        r_exp2  <= w_exp2;
        r_sign2 <= r_sign1;
        r_zero2 <= r_zero1;
        r_ovf2  <= w_ovf2;
        r_unf2  <= w_unf2;
        r_mode2 <= r_mode1;
      end
    end
  end

  assign io_bus.in_ready  = w_adv1;
  assign io_bus.out_valid = r_v2;
  assign io_bus.out_mode  = r_mode2;
  assign io_bus.sign_p    = r_sign2;
  assign io_bus.exp_p     = r_exp2;
  assign io_bus.sig_p     = r_sig2;
  assign io_bus.zero_p    = r_zero2;
  assign io_bus.ovf_p     = r_ovf2;
  assign io_bus.unf_p     = r_unf2;
endmodule

// File: tb/tb_dp_sig_mul_pipe.sv
// Directed bench for dp_sig_mul_pipe: vector table, back-to-back stream with stall, reset mid-stall.
module tb_dp_sig_mul_pipe;
  localparam int W = 200;

  typedef struct {
    logic         mode;
    logic [3:0]   sa, sb;
    logic [31:0]  ea, eb;
    logic [99:0]  siga, sigb;
    logic [3:0]   x_sign;
    logic [31:0]  x_exp;
    logic [199:0] x_sig;
    logic [3:0]   x_zero, x_ovf, x_unf;
  } vec_t;

  localparam logic [49:0] P46  = 50'd1 << 46;
  localparam logic [24:0] S1P  = 25'h0800000;
  localparam logic [24:0] S16  = 25'h0801FFF;

  vec_t vecs [8];
  logic gclk = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 gclk = ~gclk;

  dp_sig_mul_pipe_if #(.LANES(4), .EXP_W(8), .SIG_W(25)) bus ();

  dp_sig_mul_pipe dut (
    .gclk   (gclk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input int k);
    bus.in_valid = 1'b1;
    bus.mode     = vecs[k].mode;
    bus.sign_a   = vecs[k].sa;
    bus.sign_b   = vecs[k].sb;
    bus.exp_a    = vecs[k].ea;
    bus.exp_b    = vecs[k].eb;
    bus.sig_a    = vecs[k].siga;
    bus.sig_b    = vecs[k].sigb;
  endtask

  task automatic check_beat(input string tag, input int k);
    chk({tag, "_mode"}, W'(bus.out_mode), W'(vecs[k].mode));
    chk({tag, "_sign"}, W'(bus.sign_p),   W'(vecs[k].x_sign));
    chk({tag, "_exp"},  W'(bus.exp_p),    W'(vecs[k].x_exp));
    chk({tag, "_sig"},  W'(bus.sig_p),    vecs[k].x_sig);
    chk({tag, "_zero"}, W'(bus.zero_p),   W'(vecs[k].x_zero));
    chk({tag, "_ovf"},  W'(bus.ovf_p),    W'(vecs[k].x_ovf));
    chk({tag, "_unf"},  W'(bus.unf_p),    W'(vecs[k].x_unf));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, W'(bus.out_valid), W'(0));
    chk({tag, "_mode"},  W'(bus.out_mode),  W'(0));
    chk({tag, "_sign"},  W'(bus.sign_p),    W'(0));
    chk({tag, "_exp"},   W'(bus.exp_p),     W'(0));
    chk({tag, "_sig"},   W'(bus.sig_p),     W'(0));
    chk({tag, "_zero"},  W'(bus.zero_p),    W'(0));
    chk({tag, "_ovf"},   W'(bus.ovf_p),     W'(0));
    chk({tag, "_unf"},   W'(bus.unf_p),     W'(0));
  endtask

  // One beat through an empty pipe: accepted in cycle 0, valid in cycle 2.
  task automatic run_vec(input int k, input string tag);
    @(negedge gclk);
    bus.out_ready = 1'b1;
    drive(k);
    #1 chk({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    @(negedge gclk);
    bus.in_valid = 1'b0;
    #1 chk({tag, "_lat1_valid"}, W'(bus.out_valid), W'(0));
    @(negedge gclk);
    #1 chk({tag, "_lat2_valid"}, W'(bus.out_valid), W'(1));
    check_beat(tag, k);
  endtask

  initial begin
    int sent;
    int recv;

    vecs[0] = '{mode: 1'b1, sa: 4'b0101, sb: 4'b0011,
                ea: {4{8'd127}}, eb: {4{8'd127}}, siga: {4{S1P}}, sigb: {4{S1P}},
                x_sign: 4'b0110, x_exp: {4{8'd127}}, x_sig: {4{P46}},
                x_zero: 4'b0000, x_ovf: 4'b0000, x_unf: 4'b0000};
    vecs[1] = '{mode: 1'b0, sa: 4'b1111, sb: 4'b0000,
                ea: {4{8'd15}}, eb: {4{8'd15}}, siga: {4{S16}}, sigb: {4{S16}},
                x_sign: 4'b1111, x_exp: {4{8'd15}}, x_sig: {4{P46}},
                x_zero: 4'b0000, x_ovf: 4'b0000, x_unf: 4'b0000};
    vecs[2] = '{mode: 1'b1, sa: 4'b0000, sb: 4'b1000,
                ea: {8'd130, 8'd1, 8'd200, 8'd0}, eb: {8'd100, 8'd1, 8'd200, 8'd127},
                siga: {25'h1FFFFFF, S1P, S1P, S1P}, sigb: {25'h1FFFFFF, S1P, S1P, S1P},
                x_sign: 4'b1000, x_exp: {8'd103, 8'd0, 8'hFF, 8'd0},
                x_sig: {50'h3FFFFFC000001, 50'd0, P46, 50'd0},
                x_zero: 4'b0001, x_ovf: 4'b0010, x_unf: 4'b0100};
    vecs[3] = '{mode: 1'b0, sa: 4'b1100, sb: 4'b0110,
                ea: {8'd15, 8'd1, 8'd7, 8'd30}, eb: {8'd0, 8'd15, 8'd8, 8'd20},
                siga: {S1P, 25'h1FFF234, S1P, S16}, sigb: {S1P, 25'h1FFF234, S1P, S16},
                x_sign: 4'b1010, x_exp: {8'd0, 8'd1, 8'd0, 8'd31},
                x_sig: {50'd0, 50'h3FF8004000000, 50'd0, P46},
                x_zero: 4'b1000, x_ovf: 4'b0001, x_unf: 4'b0010};
    vecs[4] = '{mode: 1'b1, sa: 4'b0000, sb: 4'b0000,
                ea: {8'd63, 8'd64, 8'd200, 8'd200}, eb: {8'd64, 8'd64, 8'd182, 8'd181},
                siga: {4{S1P}}, sigb: {4{S1P}},
                x_sign: 4'b0000, x_exp: {8'd0, 8'd1, 8'hFF, 8'hFE},
                x_sig: {50'd0, P46, P46, P46},
                x_zero: 4'b0000, x_ovf: 4'b0010, x_unf: 4'b1000};
    vecs[5] = '{mode: 1'b1, sa: 4'b0011, sb: 4'b0101,
                ea: {4{8'd70}}, eb: {4{8'd70}}, siga: {4{25'h0002001}}, sigb: {4{25'h0004003}},
                x_sign: 4'b0110, x_exp: {4{8'd13}}, x_sig: {4{50'd134258691}},
                x_zero: 4'b0000, x_ovf: 4'b0000, x_unf: 4'b0000};
    vecs[6] = '{mode: 1'b0, sa: 4'b0011, sb: 4'b0101,
                ea: {4{8'd70}}, eb: {4{8'd70}}, siga: {4{25'h0002001}}, sigb: {4{25'h0004003}},
                x_sign: 4'b0110, x_exp: {4{8'd31}}, x_sig: {4{50'd134217728}},
                x_zero: 4'b0000, x_ovf: 4'b1111, x_unf: 4'b0000};
    vecs[7] = '{mode: 1'b0, sa: 4'b1111, sb: 4'b1010,
                ea: {8'd15, 8'd8, 8'd22, 8'd22}, eb: {8'd16, 8'd8, 8'd24, 8'd23},
                siga: {S1P, S1P, S1P, S1P}, sigb: {25'd0, S1P, S1P, S1P},
                x_sign: 4'b0101, x_exp: {8'd16, 8'd1, 8'd31, 8'd30},
                x_sig: {50'd0, P46, P46, P46},
                x_zero: 4'b0000, x_ovf: 4'b0010, x_unf: 4'b0000};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 1'b0;
    bus.sign_a    = '0;
    bus.sign_b    = '0;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    bus.sig_a     = '0;
    bus.sig_b     = '0;

    repeat (2) @(negedge gclk);
    #1 check_zero("reset");
    chk("reset_in_ready", W'(bus.in_ready), W'(1));
    @(negedge gclk);
    rst = 1'b0;
    #1 chk("release_in_ready", W'(bus.in_ready), W'(1));

    for (int k = 0; k < 8; k++) run_vec(k, $sformatf("vec%0d", k));

    // Back-to-back stream, downstream stalled in cycles 3..6.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      @(negedge gclk);
      bus.out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) drive(sent);
      else bus.in_valid = 1'b0;
      #1;
      chk($sformatf("stream_c%0d_in_ready", c), W'(bus.in_ready),
          W'(!((sent - recv) == 2 && !bus.out_ready)));
      if (bus.out_valid) begin
        if (recv < 8) check_beat($sformatf("stream_c%0d_b%0d", c, recv), recv);
        else chk("stream_extra_valid", W'(bus.out_valid), W'(0));
        if (bus.out_ready) recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    chk("stream_recv_count", W'(recv), W'(8));
    chk("stream_sent_count", W'(sent), W'(8));

    // Reset while both stages hold beats and the output is stalled.
    @(negedge gclk);
    bus.out_ready = 1'b0;
    drive(0);
    @(negedge gclk);
    drive(5);
    @(negedge gclk);
    bus.in_valid = 1'b0;
    #1 chk("full_in_ready", W'(bus.in_ready), W'(0));
    chk("full_out_valid", W'(bus.out_valid), W'(1));
    check_beat("full_head", 0);
    #2 rst = 1'b1;
    #1 check_zero("midstall_rst");
    chk("midstall_rst_in_ready", W'(bus.in_ready), W'(1));
    @(negedge gclk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
    chk("post_rst_valid0", W'(bus.out_valid), W'(0));
    @(negedge gclk);
    #1 chk("post_rst_valid1", W'(bus.out_valid), W'(0));
    run_vec(2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
